// File: rtl/md5_msg_buffer_if.sv
// Stream and round-read bundle between the MD5 message buffer and its neighbours.
// The master drives the message stream, the round index and the block-done pulse.
// The slave (the buffer) returns ready, the selected message word and the block status.
//   in_valid/in_ready/in_data : 32-bit message word stream
//   j                         : current round index (0..63)
//   Message                   : M[g(j)] of the active read bank
//   blk_valid/blk_done        : read-bank status and release pulse
//   blk_pending               : number of complete blocks buffered (0..2)
interface md5_msg_buffer_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [5:0]  j;
  logic [31:0] Message;
  logic        blk_valid;
  logic        blk_done;
  logic [1:0]  blk_pending;

  modport master (
    output in_valid, in_data, j, blk_done,
    input  in_ready, Message, blk_valid, blk_pending
  );

  modport slave (
    input  in_valid, in_data, j, blk_done,
    output in_ready, Message, blk_valid, blk_pending
  );
endinterface

// File: rtl/md5_msg_buffer.sv
// Double-buffered 16-word message block store feeding the MD5 round datapath.
// One bank fills from the input stream while the other is read by round index j.
//   clk : rising-edge clock
//   rst : asynchronous active-low reset
//   bus : md5_msg_buffer_if.slave (stream in, round read out, block status)
// BSWAP = 1 byte-reverses each incoming word (big-endian source).
module md5_msg_buffer #(
  parameter bit BSWAP = 1'b0
) (
  input logic              clk,
  input logic              rst,
  md5_msg_buffer_if.slave  bus
);

  logic [31:0] bank_q [2][16];
  logic        wr_bank_q, wr_bank_d;
  logic        rd_bank_q, rd_bank_d;
  logic [3:0]  wr_idx_q, wr_idx_d;
  logic [1:0]  full_q, full_d;

  logic        accept;
  logic        release_blk;
  logic        blk_valid;
  logic [31:0] wr_word;
  logic [3:0]  g;

  assign blk_valid   = full_q[rd_bank_q];
  assign accept      = bus.in_valid && !full_q[wr_bank_q];
  // A done pulse with no complete block is ignored.
  assign release_blk = bus.blk_done && blk_valid;
  assign wr_word     = BSWAP ? {bus.in_data[7:0], bus.in_data[15:8],
                                bus.in_data[23:16], bus.in_data[31:24]}
                             : bus.in_data;

  assign bus.in_ready    = !full_q[wr_bank_q];
  assign bus.blk_valid   = blk_valid;
  assign bus.blk_pending = {1'b0, full_q[0]} + {1'b0, full_q[1]};

  // Message index per round group; 4-bit arithmetic gives the mod-16 wrap.
  always_comb begin
    g = bus.j[3:0];
    unique case (bus.j[5:4])
      2'd0: g = bus.j[3:0];
      2'd1: g = bus.j[3:0] * 4'd5 + 4'd1;
      2'd2: g = bus.j[3:0] * 4'd3 + 4'd5;
      2'd3: g = bus.j[3:0] * 4'd7;
      default: g = bus.j[3:0];
    endcase
  end

  assign bus.Message = blk_valid ? bank_q[rd_bank_q][g] : 32'h0;

  // The filling bank is never full, so fill and release never hit the same bank.
  always_comb begin
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    wr_idx_d  = wr_idx_q;
    full_d    = full_q;
    if (accept) begin
      wr_idx_d = wr_idx_q + 4'd1;
      if (wr_idx_q == 4'd15) begin
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = !wr_bank_q;
      end
    end
    if (release_blk) begin
      full_d[rd_bank_q] = 1'b0;
      rd_bank_d         = !rd_bank_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      wr_idx_q  <= 4'd0;
      full_q    <= 2'b00;
    end else begin
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      wr_idx_q  <= wr_idx_d;
      full_q    <= full_d;
    end
  end

  // Bank storage is not reset; full_q gates every read.
  always_ff @(posedge clk) begin
    if (accept) begin
      bank_q[wr_bank_q][wr_idx_q] <= wr_word;
    end
  end

endmodule

// File: tb/tb_md5_msg_buffer.sv
module tb_md5_msg_buffer;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_checks = 0;
  int   n_fails  = 0;

  md5_msg_buffer_if bus ();
  md5_msg_buffer_if bus_sw ();

  md5_msg_buffer #(.BSWAP(1'b0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  md5_msg_buffer #(.BSWAP(1'b1)) dut_sw (
    .clk (clk),
    .rst (rst),
    .bus (bus_sw.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_msg(input string tag, input logic [5:0] jj, input logic [31:0] exp);
    bus.j = jj;
    #1;
    chk(tag, bus.Message, exp);
  endtask

  // Called at a negedge; sends base+i for i = first..last, optionally pulsing
  // blk_done together with the last word.
  task automatic send_words(input logic [31:0] base, input int first, input int last,
                            input bit done_last);
    for (int i = first; i <= last; i++) begin
      chk("in_ready_stream", 32'(bus.in_ready), 32'd1);
      bus.in_valid = 1'b1;
      bus.in_data  = base + 32'(i);
      bus.blk_done = done_last && (i == last);
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    bus.blk_done = 1'b0;
  endtask

  task automatic pulse_done();
    bus.blk_done = 1'b1;
    @(negedge clk);
    bus.blk_done = 1'b0;
  endtask

  initial begin
    bus.in_valid    = 1'b0;
    bus.in_data     = '0;
    bus.j           = '0;
    bus.blk_done    = 1'b0;
    bus_sw.in_valid = 1'b0;
    bus_sw.in_data  = '0;
    bus_sw.j        = '0;
    bus_sw.blk_done = 1'b0;

    // Reset state
    #2;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_blk_valid", 32'(bus.blk_valid), 32'd0);
    chk("rst_pending", 32'(bus.blk_pending), 32'd0);
    chk("rst_message", bus.Message, 32'h0);
    @(negedge clk);
    rst = 1'b1;

    // Block of words 0..15; valid exactly after the 16th accept
    send_words(32'h0, 0, 14, 1'b0);
    chk("blk0_not_yet_valid", 32'(bus.blk_valid), 32'd0);
    chk("blk0_msg_gated", bus.Message, 32'h0);
    send_words(32'h0, 15, 15, 1'b0);
    chk("blk0_valid", 32'(bus.blk_valid), 32'd1);
    chk("blk0_pending", 32'(bus.blk_pending), 32'd1);
    chk("blk0_in_ready", 32'(bus.in_ready), 32'd1);

    // Round-index permutation
    chk_msg("msg_j0", 6'd0, 32'h0);
    chk_msg("msg_j16", 6'd16, 32'h1);
    chk_msg("msg_j17", 6'd17, 32'h6);
    chk_msg("msg_j32", 6'd32, 32'h5);
    chk_msg("msg_j33", 6'd33, 32'h8);
    chk_msg("msg_j48", 6'd48, 32'h0);
    chk_msg("msg_j63", 6'd63, 32'h9);
    chk_msg("msg_j15", 6'd15, 32'hF);
    bus.j = 6'd0;

    // Fresh start, then fill both banks
    rst = 1'b0;
    #1;
    rst = 1'b1;
    @(negedge clk);
    send_words(32'h100, 0, 15, 1'b0);
    send_words(32'h200, 0, 15, 1'b0);
    chk("two_pending", 32'(bus.blk_pending), 32'd2);
    chk("two_in_ready", 32'(bus.in_ready), 32'd0);
    chk("two_msg_j0", bus.Message, 32'h100);

    // 33rd word must stall
    bus.in_valid = 1'b1;
    bus.in_data  = 32'h300;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_in_ready", 32'(bus.in_ready), 32'd0);
      chk("stall_pending", 32'(bus.blk_pending), 32'd2);
    end
    bus.blk_done = 1'b1;
    @(negedge clk);
    bus.blk_done = 1'b0;
    chk("freed_msg_j0", bus.Message, 32'h200);
    chk("freed_pending", 32'(bus.blk_pending), 32'd1);
    chk("freed_in_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("after_stall_pending", 32'(bus.blk_pending), 32'd1);

    // blk_done on the same cycle as the 16th accept of the next block
    send_words(32'h300, 1, 15, 1'b1);
    chk("overlap_blk_valid", 32'(bus.blk_valid), 32'd1);
    chk("overlap_pending", 32'(bus.blk_pending), 32'd1);
    chk("overlap_in_ready", 32'(bus.in_ready), 32'd1);
    chk_msg("overlap_msg_j0", 6'd0, 32'h300);
    chk_msg("overlap_msg_j1", 6'd1, 32'h301);
    bus.j = 6'd0;
    @(negedge clk);

    // Retire it, then a spurious done must change nothing
    pulse_done();
    chk("empty_blk_valid", 32'(bus.blk_valid), 32'd0);
    chk("empty_pending", 32'(bus.blk_pending), 32'd0);
    pulse_done();
    chk("spur_in_ready", 32'(bus.in_ready), 32'd1);
    chk("spur_blk_valid", 32'(bus.blk_valid), 32'd0);
    chk("spur_pending", 32'(bus.blk_pending), 32'd0);
    chk("spur_message", bus.Message, 32'h0);
    send_words(32'h400, 0, 15, 1'b0);
    chk("spur_then_fill_valid", 32'(bus.blk_valid), 32'd1);
    chk("spur_then_fill_msg", bus.Message, 32'h400);

    // Async reset after 7 words of a partial block, between clock edges
    send_words(32'h500, 0, 6, 1'b0);
    chk("partial_pending", 32'(bus.blk_pending), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("async_in_ready", 32'(bus.in_ready), 32'd1);
    chk("async_pending", 32'(bus.blk_pending), 32'd0);
    chk("async_blk_valid", 32'(bus.blk_valid), 32'd0);
    chk("async_message", bus.Message, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    send_words(32'h600, 0, 14, 1'b0);
    chk("restart_not_valid", 32'(bus.blk_valid), 32'd0);
    send_words(32'h600, 15, 15, 1'b0);
    chk("restart_valid", 32'(bus.blk_valid), 32'd1);
    chk_msg("restart_msg_j0", 6'd0, 32'h600);
    chk_msg("restart_msg_j15", 6'd15, 32'h60F);
    bus.j = 6'd0;
    @(negedge clk);

    // Byte-swapping instance
    for (int i = 0; i < 16; i++) begin
      bus_sw.in_valid = 1'b1;
      bus_sw.in_data  = (i == 0) ? 32'h11223344 : 32'(i);
      @(negedge clk);
    end
    bus_sw.in_valid = 1'b0;
    bus_sw.j = 6'd0;
    #1;
    chk("bswap_valid", 32'(bus_sw.blk_valid), 32'd1);
    chk("bswap_msg_j0", bus_sw.Message, 32'h44332211);
    bus_sw.j = 6'd1;
    #1;
    chk("bswap_msg_j1", bus_sw.Message, 32'h01000000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
